// File: rtl/jtkunio_ba_arb_pkg.sv
// jtkunio_ba_arb_pkg: shared state encoding, default burst/timeout and one-hot helper
package jtkunio_ba_arb_pkg;
  typedef enum logic [1:0] {IDLE, CMD, RDATA, WDONE} st_t;
  localparam int BURST_DEF = 2;
  localparam int TOUT_DEF  = 255;
  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction
endpackage

// File: rtl/jtkunio_ba_arb_if.sv
// jtkunio_ba_arb_if: bank, programming and SDRAM front-end signals of the arbiter
interface jtkunio_ba_arb_if;
  logic [21:0] ba0_addr, ba1_addr, ba2_addr, ba3_addr;
  logic [3:0]  ba_rd, ba_ack, ba_dst, ba_dok, ba_rdy;
  logic [15:0] data_read;
  logic        downloading;
  logic [21:0] prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask, prog_ba;
  logic        prog_we, prog_rd, prog_ack, prog_rdy;
  logic        sdr_req, sdr_wr;
  logic [1:0]  sdr_ba, sdr_mask;
  logic [21:0] sdr_addr;
  logic [15:0] sdr_din, sdr_dout;
  logic        sdr_gnt, sdr_dvalid, sdr_wdone;
  modport master (
    input  ba0_addr, ba1_addr, ba2_addr, ba3_addr, ba_rd, downloading,
           prog_addr, prog_data, prog_mask, prog_ba, prog_we, prog_rd,
           sdr_gnt, sdr_dvalid, sdr_dout, sdr_wdone,
    output ba_ack, ba_dst, ba_dok, ba_rdy, data_read, prog_ack, prog_rdy,
           sdr_req, sdr_wr, sdr_ba, sdr_addr, sdr_din, sdr_mask
  );
  modport slave (
    output ba0_addr, ba1_addr, ba2_addr, ba3_addr, ba_rd, downloading,
           prog_addr, prog_data, prog_mask, prog_ba, prog_we, prog_rd,
           sdr_gnt, sdr_dvalid, sdr_dout, sdr_wdone,
    input  ba_ack, ba_dst, ba_dok, ba_rdy, data_read, prog_ack, prog_rdy,
           sdr_req, sdr_wr, sdr_ba, sdr_addr, sdr_din, sdr_mask
  );
endinterface

// File: rtl/jtkunio_rr4.sv
// jtkunio_rr4: 4-way round-robin picker searching upward from ptr
module jtkunio_rr4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic       valid
);
  logic [1:0] k;
  // walk offsets from farthest to nearest so the nearest requester wins
  always_comb begin
    gnt = '0;
    k   = '0;
    for (int i = 3; i >= 0; i--) begin
      k = ptr + 2'(i);
      if (req[k]) gnt = 4'b1 << k;
    end
  end
  assign valid = |req;
endmodule

// File: rtl/jtkunio_ba_arb.sv
// jtkunio_ba_arb: four-bank SDRAM read arbiter with ROM-download programming path
module jtkunio_ba_arb
  import jtkunio_ba_arb_pkg::*;
#(
  parameter int BURST = BURST_DEF,
  parameter int TOUT  = TOUT_DEF
) (
  input logic              clk,
  input logic              rst_n,
  jtkunio_ba_arb_if.master bus
);
  localparam int TW = $clog2(TOUT + 1);
  st_t           st, st_nx;
  logic [1:0]    ptr, bank, win;
  logic          sel_prog, wcnt;
  logic [TW-1:0] tcnt;
  logic [3:0]    gnt, ack_nx, dst_nx, dok_nx, rdy_nx;
  logic          gvalid, go_prog, go_bank, tout, last, pack_nx, prdy_nx;

  jtkunio_rr4 u_rr (.req(bus.ba_rd), .ptr(ptr), .gnt(gnt), .valid(gvalid));
  assign win = oh2idx(gnt);

  // next state and the pulses to register this cycle
  always_comb begin
    st_nx   = st;
    ack_nx  = '0;
    dst_nx  = '0;
    dok_nx  = '0;
    rdy_nx  = '0;
    pack_nx = 1'b0;
    prdy_nx = 1'b0;
    go_prog = st == IDLE && bus.downloading && (bus.prog_we || bus.prog_rd);
    go_bank = st == IDLE && !bus.downloading && gvalid;
    tout    = tcnt == TW'(TOUT - 1);
    last    = wcnt == 1'(BURST - 1);
    case (st)
      IDLE: st_nx = (go_prog || go_bank) ? CMD : IDLE;
      CMD:
        if (bus.sdr_gnt) begin
          st_nx   = (sel_prog && bus.sdr_wr) ? WDONE : RDATA;
          pack_nx = sel_prog;
          ack_nx  = sel_prog ? 4'b0 : 4'b1 << bank;
        end else if (tout) st_nx = IDLE;
      RDATA:
        if (bus.sdr_dvalid) begin
          dok_nx = sel_prog ? 4'b0 : 4'b1 << bank;
          dst_nx = (sel_prog || wcnt) ? 4'b0 : 4'b1 << bank;
          if (last) begin
            st_nx   = IDLE;
            rdy_nx  = sel_prog ? 4'b0 : 4'b1 << bank;
            prdy_nx = sel_prog;
          end
        end else if (tout) st_nx = IDLE;
      default:
        if (bus.sdr_wdone) begin
          st_nx   = IDLE;
          prdy_nx = 1'b1;
        end else if (tout) st_nx = IDLE;
    endcase
  end

  // state register; the timeout counter restarts on every state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= IDLE;
      tcnt <= '0;
    end else begin
      st   <= st_nx;
      tcnt <= (st_nx != st) ? '0 : tcnt + 1'b1;
    end
  end

  // grant latch, SDRAM command, read data and output pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr           <= '0;
      bank          <= '0;
      sel_prog      <= 1'b0;
      wcnt          <= 1'b0;
      bus.sdr_req   <= 1'b0;
      bus.sdr_wr    <= 1'b0;
      bus.sdr_ba    <= '0;
      bus.sdr_addr  <= '0;
      bus.sdr_din   <= '0;
      bus.sdr_mask  <= '0;
      bus.data_read <= '0;
      bus.ba_ack    <= '0;
      bus.ba_dst    <= '0;
      bus.ba_dok    <= '0;
      bus.ba_rdy    <= '0;
      bus.prog_ack  <= 1'b0;
      bus.prog_rdy  <= 1'b0;
    end else begin
      bus.sdr_req  <= st_nx == CMD;
      bus.ba_ack   <= ack_nx;
      bus.ba_dst   <= dst_nx;
      bus.ba_dok   <= dok_nx;
      bus.ba_rdy   <= rdy_nx;
      bus.prog_ack <= pack_nx;
      bus.prog_rdy <= prdy_nx;
      if (st == IDLE) wcnt <= 1'b0;
      else if (st == RDATA && bus.sdr_dvalid) wcnt <= wcnt + 1'b1;
      if (st == RDATA && bus.sdr_dvalid) bus.data_read <= bus.sdr_dout;
      if (go_prog) begin
        sel_prog     <= 1'b1;
        bus.sdr_wr   <= bus.prog_we;
        bus.sdr_ba   <= bus.prog_ba;
        bus.sdr_addr <= bus.prog_addr;
        bus.sdr_din  <= bus.prog_data;
        bus.sdr_mask <= bus.prog_mask;
      end else if (go_bank) begin
        sel_prog     <= 1'b0;
        bank         <= win;
        ptr          <= win + 2'd1;
        bus.sdr_wr   <= 1'b0;
        bus.sdr_ba   <= win;
        bus.sdr_addr <= win == 2'd0 ? bus.ba0_addr :
                        win == 2'd1 ? bus.ba1_addr :
                        win == 2'd2 ? bus.ba2_addr : bus.ba3_addr;
        bus.sdr_din  <= '0;
        bus.sdr_mask <= '0;
      end
    end
  end
endmodule

// File: doc/jtkunio_ba_arb.md
JTKUNIO_BA_ARB -- requirements
Module: jtkunio_ba_arb

Interface
REQ-001 Parameters SHALL be:
  - BURST, default 2: data words per read (1 or 2).
  - TOUT, default 255: cycles allowed for sdr_gnt/data before the state machine aborts.
REQ-002 clk  in  1  system clock; all logic rising-edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 ba0_addr..ba3_addr  in  22 each  per-bank read word address.
REQ-005 ba_rd  in  4  per-bank read request, level, held until ba_ack.
REQ-006 ba_ack  out  4  one-cycle pulse: request accepted by SDRAM front-end.
REQ-007 ba_dst  out  4  one-cycle pulse with first data word of a read.
REQ-008 ba_dok  out  4  high on each cycle data_read is valid for that bank.
REQ-009 ba_rdy  out  4  one-cycle pulse with last data word.
REQ-010 data_read  out  16  registered read data shared by all banks.
REQ-011 downloading  in  1  high during ROM load; enables prog path.
REQ-012 prog_addr 22, prog_data 16, prog_mask 2 (active low), prog_ba 2, prog_we 1, prog_rd 1  in  programming command.
REQ-013 prog_ack  out  1  one-cycle pulse when prog command accepted.
REQ-014 prog_rdy  out  1  one-cycle pulse when write/read-back completes.
REQ-015 sdr_req  out  1; sdr_wr  out  1; sdr_ba  out  2; sdr_addr  out  22; sdr_din  out  16; sdr_mask  out  2: command to SDRAM front-end, stable while sdr_req high.
REQ-016 sdr_gnt  in  1  front-end accepted command this cycle.
REQ-017 sdr_dvalid  in  1  read data word valid on sdr_dout; sdr_dout  in  16; sdr_wdone  in  1  write finished.

Function
REQ-018 State machine SHALL have states IDLE, CMD, RDATA, WDONE.
REQ-019 IDLE: if downloading and (prog_we|prog_rd) -> CMD with prog source; else if any ba_rd -> CMD with round-robin winner; else stay.
REQ-020 Round-robin SHALL search from pointer ptr upward modulo 4; after a grant to bank n, ptr SHALL become (n+1) mod 4.
REQ-021 Grant SHALL be registered on IDLE exit; sdr_req asserts the cycle after selection and address/ba are latched then.
REQ-022 While downloading is high, bank requests SHALL NOT be granted; they stay pending.
REQ-023 CMD: on sdr_gnt, drop sdr_req the same cycle; pulse ba_ack[n] or prog_ack; go to RDATA (read) or WDONE (prog_we).
REQ-024 RDATA: each sdr_dvalid registers sdr_dout into data_read and raises ba_dok[n] next cycle; first word also pulses ba_dst[n]; word BURST also pulses ba_rdy[n] (or prog_rdy for prog_rd), then -> IDLE.
REQ-025 WDONE: on sdr_wdone pulse prog_rdy, -> IDLE.
REQ-026 Word counter SHALL be 1 bit wide for BURST<=2; sdr_dvalid in IDLE/CMD SHALL be ignored.
REQ-027 A timeout counter SHALL reset on each state entry; reaching TOUT in CMD/RDATA/WDONE SHALL return to IDLE without ack/rdy pulses for the aborted word.
REQ-028 ba_rd deasserting after grant SHALL NOT cancel the transaction.
REQ-029 At most one bit of ba_ack|ba_dst|ba_dok|ba_rdy SHALL be set in any cycle.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, ptr 0, all pulse/strobe outputs 0, sdr_req 0, data_read 0, counters 0; sdr_addr/sdr_din/sdr_ba/sdr_mask/sdr_wr 0.
REQ-031 Reset mid-transaction SHALL discard it; no pulse SHALL follow reset release until a new grant.

Structure
REQ-032 State encoding and BURST/TOUT defaults SHALL live in the shared jtkunio package.
REQ-033 Round-robin selection SHALL be sub-module jtkunio_rr4 (4 requests, pointer in, one-hot grant plus valid out, combinational).

Verification
REQ-034 ba_rd=4'b0101, ptr 0, no downloading -> bank0 acked first, then bank2; ptr ends at 3.
REQ-035 All four ba_rd held high for 8 transactions -> grant order 0,1,2,3,0,1,2,3.
REQ-036 Bank1 read with sdr_dout 16'h1234 then 16'hABCD -> ba_dst[1] with 1234; ba_dok[1] two cycles; ba_rdy[1] with ABCD.
REQ-037 downloading=1, prog_we with addr 22'h10, data 16'h55AA, mask 2'b00, ba_rd=4'hF -> only prog_ack/prog_rdy; no ba_ack until downloading=0.
REQ-038 sdr_gnt never asserted for TOUT=255 cycles -> state returns to IDLE at cycle 255 with no ba_ack.
REQ-039 rst_n pulled low between first and second data words -> all outputs 0 asynchronously; no ba_rdy after release.
